// File: rtl/vga_timing_detector_if.sv
// Interface bundle for the VGA timing detector: incoming sync pair plus lock status,
// measurement results and reconstructed pixel position.
interface vga_timing_detector_if;
    logic        h_sync_in;
    logic        v_sync_in;
    logic        locked;
    logic        mode_err;
    logic        frame_start;
    logic [10:0] h_total_meas;
    logic [10:0] h_pulse_meas;
    logic [10:0] v_total_meas;
    logic [10:0] v_pulse_meas;
    logic [10:0] pos_x;
    logic [10:0] pos_y;

    // The sync source drives the pair and observes the detector's results.
    modport master (
        output h_sync_in, v_sync_in,
        input  locked, mode_err, frame_start,
        input  h_total_meas, h_pulse_meas, v_total_meas, v_pulse_meas,
        input  pos_x, pos_y
    );

    modport slave (
        input  h_sync_in, v_sync_in,
        output locked, mode_err, frame_start,
        output h_total_meas, h_pulse_meas, v_total_meas, v_pulse_meas,
        output pos_x, pos_y
    );
endinterface

// File: rtl/vga_timing_detector.sv
// VGA timing detector: measures incoming hsync/vsync timing, locks onto the expected mode and
// tracks pixel position. Define VGA_IN_SYNC_EN to add a 2-flop synchronizer on both sync inputs.
module vga_timing_detector #(
    parameter int H_TOTAL     = 1688,
    parameter int H_PULSE     = 112,
    parameter int V_TOTAL     = 1066,
    parameter int V_PULSE     = 3,
    parameter int LOCK_FRAMES = 2
) (
    input logic                  clk,
    input logic                  rst,
    vga_timing_detector_if.slave bus
);

    localparam logic [10:0] CNT_MAX   = 11'h7FF;
    localparam logic [10:0] EXP_H_TOT = 11'(H_TOTAL);
    localparam logic [10:0] EXP_H_PUL = 11'(H_PULSE);
    localparam logic [10:0] EXP_V_TOT = 11'(V_TOTAL);
    localparam logic [10:0] EXP_V_PUL = 11'(V_PULSE);
    localparam logic [3:0]  LOCK_CNT  = 4'(LOCK_FRAMES);

    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic        hsQ;
    logic        vsQ;
    logic        hsD;
    logic        vsD;
    logic        hRise;
    logic        hFall;
    logic        vRise;
    logic        vFall;

    logic [10:0] hCnt;
    logic [10:0] vCnt;
    logic [11:0] hCntInc;
    logic [10:0] hMeasNext;
    logic [10:0] hCntNext;
    logic [10:0] vCntNext;
    logic        timeoutHold;
    logic        timeoutEntry;

    logic [10:0] hTotalMeas;
    logic [10:0] hPulseMeas;
    logic [10:0] vTotalMeas;
    logic [10:0] vPulseMeas;
    logic [10:0] hTotalNew;
    logic [10:0] hPulseNew;
    logic [10:0] vPulseNew;
    logic        frameOk;

    logic [3:0]  matchCnt;
    logic [3:0]  matchInc;
    logic        vSeen;
    logic [0:0]  state;
    logic        modeErr;
    logic        frameStart;

`ifdef VGA_IN_SYNC_EN
    logic [1:0] hsSync;
    logic [1:0] vsSync;

    // Synchronizer flops reset high so a sync already high at release is not seen as a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsSync <= 2'b11;
            vsSync <= 2'b11;
        end else begin
            hsSync <= {hsSync[0], bus.h_sync_in};
            vsSync <= {vsSync[0], bus.v_sync_in};
        end
    end

    assign hsQ = hsSync[1];
    assign vsQ = vsSync[1];
`else
    assign hsQ = bus.h_sync_in;
    assign vsQ = bus.v_sync_in;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            hsD <= 1'b1;
            vsD <= 1'b1;
        end else begin
            hsD <= hsQ;
            vsD <= vsQ;
        end
    end

    assign hRise = hsQ & ~hsD;
    assign hFall = ~hsQ & hsD;
    assign vRise = vsQ & ~vsD;
    assign vFall = ~vsQ & vsD;

    // hMeasNext is the saturated count including the current clock; it doubles as the next h_cnt.
    assign hCntInc      = {1'b0, hCnt} + 12'd1;
    assign hMeasNext    = hCntInc[11] ? CNT_MAX : hCntInc[10:0];
    assign hCntNext     = hRise ? 11'd0 : hMeasNext;
    assign vCntNext     = (hRise && (vCnt != CNT_MAX)) ? vCnt + 11'd1 : vCnt;
    assign timeoutHold  = (hCntNext == CNT_MAX);
    assign timeoutEntry = timeoutHold && (hCnt != CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            hCnt       <= 11'd0;
            hTotalMeas <= 11'd0;
            hPulseMeas <= 11'd0;
        end else begin
            hCnt <= hCntNext;
            if (hRise) begin
                hTotalMeas <= hMeasNext;
            end
            if (hFall) begin
                hPulseMeas <= hMeasNext;
            end
        end
    end

    // A line that starts together with vsync is line 0 of the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            vCnt       <= 11'd0;
            vTotalMeas <= 11'd0;
            vPulseMeas <= 11'd0;
            frameStart <= 1'b0;
        end else begin
            frameStart <= vRise;
            if (vRise) begin
                vTotalMeas <= vCntNext;
                vCnt       <= 11'd0;
            end else begin
                vCnt <= vCntNext;
            end
            if (vFall) begin
                vPulseMeas <= vCntNext;
            end
        end
    end

    assign hTotalNew = hRise ? hMeasNext : hTotalMeas;
    assign hPulseNew = hFall ? hMeasNext : hPulseMeas;
    assign vPulseNew = vFall ? vCntNext : vPulseMeas;
    assign frameOk   = (hTotalNew == EXP_H_TOT) && (hPulseNew == EXP_H_PUL) &&
                       (vCntNext == EXP_V_TOT) && (vPulseNew == EXP_V_PUL);
    assign matchInc  = (matchCnt >= LOCK_CNT) ? LOCK_CNT : matchCnt + 4'd1;

    // Lock tracking: the first vsync after reset or timeout only arms checking; after that every
    // vsync judges the frame just ended. Loss of hsync overrides any frame verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            matchCnt <= 4'd0;
            vSeen    <= 1'b0;
            state    <= SEARCH;
            modeErr  <= 1'b0;
        end else begin
            modeErr <= 1'b0;
            if (timeoutHold) begin
                matchCnt <= 4'd0;
                vSeen    <= 1'b0;
                state    <= SEARCH;
                modeErr  <= timeoutEntry;
            end else if (vRise) begin
                if (!vSeen) begin
                    vSeen <= 1'b1;
                end else if (frameOk) begin
                    matchCnt <= matchInc;
                    if (matchInc == LOCK_CNT) begin
                        state <= LOCKED;
                    end
                end else begin
                    matchCnt <= 4'd0;
                    state    <= SEARCH;
                    modeErr  <= 1'b1;
                end
            end
        end
    end

    assign bus.locked       = (state == LOCKED);
    assign bus.mode_err     = modeErr;
    assign bus.frame_start  = frameStart;
    assign bus.h_total_meas = hTotalMeas;
    assign bus.h_pulse_meas = hPulseMeas;
    assign bus.v_total_meas = vTotalMeas;
    assign bus.v_pulse_meas = vPulseMeas;
    assign bus.pos_x        = hCnt;
    assign bus.pos_y        = vCnt;

endmodule

// File: tb/tb_vga_timing_detector.sv
// Bench for vga_timing_detector using a scaled-down mode (40 clk/line, 6 clk hsync, 12 lines,
// 3 line vsync); expectations are queued at each vsync rise and checked when frame_start appears.
`timescale 1ns/1ps
module tb_vga_timing_detector;

    localparam int HT = 40;
    localparam int HP = 6;
    localparam int VT = 12;
    localparam int VP = 3;
    localparam int LF = 2;
`ifdef VGA_IN_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int expCycle;
        bit chkMeas;
        int hTot;
        int hPul;
        int vTot;
        int vPul;
        bit lockedExp;
        bit errExp;
    } FrameExp;

    logic    clk = 1'b0;
    logic    rst;
    int      cyc = 0;
    int      checks = 0;
    int      failures = 0;
    int      errCount = 0;
    int      prevLastLen = 0;
    int      prevLines = 0;
    int      prevVs = 0;
    bit      fallSeen;
    FrameExp expQ[$];
    FrameExp mon;

    vga_timing_detector_if bus();

    vga_timing_detector #(
        .H_TOTAL(HT), .H_PULSE(HP), .V_TOTAL(VT), .V_PULSE(VP), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic h, input logic v);
        @(posedge clk);
        #1;
        bus.h_sync_in = h;
        bus.v_sync_in = v;
    endtask

    // One frame starting with coincident hsync/vsync rise; line 5 may be stretched via midLen.
    task automatic sendFrame(input int nLines, input int vsLines, input int lastLen, input int midLen,
                             input bit chkMeas, input bit lockedExp, input bit errExp);
        FrameExp e;
        int      len;
        for (int l = 0; l < nLines; l++) begin
            len = (l == nLines - 1) ? lastLen : ((l == 5) ? midLen : HT);
            for (int i = 0; i < len; i++) begin
                applyStimulus(i < HP, l < vsLines);
                if (l == 0 && i == 0) begin
                    e.expCycle  = cyc + LAT;
                    e.chkMeas   = chkMeas;
                    e.hTot      = prevLastLen;
                    e.hPul      = HP;
                    e.vTot      = prevLines;
                    e.vPul      = prevVs;
                    e.lockedExp = lockedExp;
                    e.errExp    = errExp;
                    expQ.push_back(e);
                end
            end
        end
        prevLastLen = lastLen;
        prevLines   = nLines;
        prevVs      = vsLines;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Locked"}, int'(bus.locked), 0);
        checkOutput({tag, "ModeErr"}, int'(bus.mode_err), 0);
        checkOutput({tag, "FrameStart"}, int'(bus.frame_start), 0);
        checkOutput({tag, "HTotal"}, int'(bus.h_total_meas), 0);
        checkOutput({tag, "HPulse"}, int'(bus.h_pulse_meas), 0);
        checkOutput({tag, "VTotal"}, int'(bus.v_total_meas), 0);
        checkOutput({tag, "VPulse"}, int'(bus.v_pulse_meas), 0);
        checkOutput({tag, "PosX"}, int'(bus.pos_x), 0);
        checkOutput({tag, "PosY"}, int'(bus.pos_y), 0);
    endtask

    // Monitor: every frame_start pops one expectation; mode_err pulses are tallied separately.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mode_err) errCount++;
            if (bus.frame_start) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedFrameStart", 1, 0);
                end else begin
                    mon = expQ.pop_front();
                    checkOutput("frameStartCycle", cyc, mon.expCycle);
                    checkOutput("lockedAtFrame", int'(bus.locked), int'(mon.lockedExp));
                    checkOutput("modeErrAtFrame", int'(bus.mode_err), int'(mon.errExp));
                    checkOutput("posXAtFrame", int'(bus.pos_x), 0);
                    checkOutput("posYAtFrame", int'(bus.pos_y), 0);
                    if (mon.chkMeas) begin
                        checkOutput("hTotalMeas", int'(bus.h_total_meas), mon.hTot);
                        checkOutput("hPulseMeas", int'(bus.h_pulse_meas), mon.hPul);
                        checkOutput("vTotalMeas", int'(bus.v_total_meas), mon.vTot);
                        checkOutput("vPulseMeas", int'(bus.v_pulse_meas), mon.vPul);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.h_sync_in = 1'b0;
        bus.v_sync_in = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) applyStimulus(1'b0, 1'b0);

        // Nominal stream: first vsync arms, two passes lock.
        sendFrame(VT, VP, HT, HT, 1'b0, 1'b0, 1'b0);
        sendFrame(VT, VP, HT, HT, 1'b1, 1'b0, 1'b0);
        sendFrame(VT, VP, HT, HT, 1'b1, 1'b1, 1'b0);
        checkOutput("errCountNominal", errCount, 0);

        // Last line stretched by 2 clocks, then relock; a mid-frame stretch does not break lock.
        sendFrame(VT, VP, HT + 2, HT, 1'b1, 1'b1, 1'b0);
        sendFrame(VT, VP, HT, HT, 1'b1, 1'b0, 1'b1);
        sendFrame(VT, VP, HT, HT, 1'b1, 1'b0, 1'b0);
        sendFrame(VT, VP, HT, HT + 5, 1'b1, 1'b1, 1'b0);

        // Vsync four lines wide for two frames, then clean frames.
        sendFrame(VT, 4, HT, HT, 1'b1, 1'b1, 1'b0);
        sendFrame(VT, 4, HT, HT, 1'b1, 1'b0, 1'b1);
        sendFrame(VT, VP, HT, HT, 1'b1, 1'b0, 1'b1);
        sendFrame(VT, VP, HT, HT, 1'b1, 1'b0, 1'b0);
        sendFrame(5, VP, HT, HT, 1'b1, 1'b1, 1'b0);
        checkOutput("errCountBeforeTimeout", errCount, 3);
        checkOutput("lockedBeforeTimeout", int'(bus.locked), 1);

        // Hsync lost for 3000 clocks.
        fallSeen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(1'b0, 1'b0);
            @(negedge clk);
            if (!fallSeen && !bus.locked) begin
                fallSeen = 1'b1;
                checkOutput("posXAtLockLoss", int'(bus.pos_x), 2047);
            end
        end
        checkOutput("timeoutLockFell", int'(fallSeen), 1);
        checkOutput("posXHeld", int'(bus.pos_x), 2047);
        checkOutput("errCountAfterTimeout", errCount, 4);

        sendFrame(VT, VP, HT, HT, 1'b0, 1'b0, 1'b0);
        sendFrame(VT, VP, HT, HT, 1'b1, 1'b0, 1'b0);
        sendFrame(6, VP, HT, HT, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("lockedBeforeReset", int'(bus.locked), 1);

        // Reset mid-frame with both syncs high through release.
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.h_sync_in = 1'b1;
        bus.v_sync_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("midReset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        checkOutput("releaseLocked", int'(bus.locked), 0);
        checkOutput("releaseHTotal", int'(bus.h_total_meas), 0);
        checkOutput("releaseVTotal", int'(bus.v_total_meas), 0);
        checkOutput("errCountAfterReset", errCount, 4);
        repeat (5) applyStimulus(1'b0, 1'b0);

        sendFrame(VT, VP, HT, HT, 1'b0, 1'b0, 1'b0);
        sendFrame(VT, VP, HT, HT, 1'b1, 1'b0, 1'b0);
        sendFrame(VT, VP, HT, HT, 1'b1, 1'b1, 1'b0);
        sendFrame(2, VP, HT, HT, 1'b1, 1'b1, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("pendingExpectations", expQ.size(), 0);
        checkOutput("errCountFinal", errCount, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
